// File: rtl/router_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | router_pkg                                                           |
// | Shared types and constants for the 1x3 router control FSM.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  // Address 2'b11 never maps to a FIFO, whatever the port count.
  function automatic logic addr_valid(input logic [1:0] addr, input int num_ports);
    return (addr != ADDR_INVALID) && (int'(addr) < num_ports);
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | router_fsm                                                           |
// | Control FSM of the 1x3 router: address decode, datapath strobes,     |
// | FIFO write enable and source back-pressure.                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module router_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PORTS  = router_pkg::NUM_PORTS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic [NUM_PORTS-1:0]  fifo_empty,
  input  logic [NUM_PORTS-1:0]  soft_reset,
  input  logic                  parity_done,
  input  logic                  low_pkt_valid,
  output logic                  detect_add,
  output logic                  lfd_state,
  output logic                  ld_state,
  output logic                  laf_state,
  output logic                  full_state,
  output logic                  rst_int_reg,
  output logic                  write_enb_reg,
  output logic                  busy,
  output logic [1:0]            dest_addr
);
  import router_pkg::*;

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_dest_addr;

  logic [1:0] w_hdr_addr;
  logic       w_hdr_ok;
  logic [3:0] w_empty_vec;
  logic [3:0] w_soft_vec;
  logic       w_soft_sel;
  logic       w_unused_data;

  assign w_hdr_addr  = data_in[1:0];
  assign w_hdr_ok    = pkt_valid && addr_valid(w_hdr_addr, NUM_PORTS);
  // Zero-extended so any 2-bit address indexes safely; invalid ports read 0.
  assign w_empty_vec = 4'(fifo_empty);
  assign w_soft_vec  = 4'(soft_reset);
  assign w_soft_sel  = w_soft_vec[r_dest_addr];

  generate
    if (DATA_WIDTH > 2) begin : g_upper_data
      assign w_unused_data = ^data_in[DATA_WIDTH-1:2];
    end else begin : g_no_upper_data
      assign w_unused_data = 1'b0;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= DECODE_ADDRESS;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_dest_addr <= 2'd0;
    end else if ((r_state == DECODE_ADDRESS) && w_hdr_ok) begin
      r_dest_addr <= w_hdr_addr;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      DECODE_ADDRESS: begin
        if (w_hdr_ok) begin
          w_next_state = w_empty_vec[w_hdr_addr] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (w_empty_vec[r_dest_addr]) begin
          w_next_state = LOAD_FIRST_DATA;
        end
      end
      LOAD_FIRST_DATA: w_next_state = LOAD_DATA;
      LOAD_DATA: begin
        // A full FIFO takes priority over the end of the packet.
        if (fifo_full) begin
          w_next_state = FIFO_FULL_STATE;
        end else if (!pkt_valid) begin
          w_next_state = LOAD_PARITY;
        end
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) begin
          w_next_state = LOAD_AFTER_FULL;
        end
      end
      LOAD_AFTER_FULL: begin
        if (parity_done) begin
          w_next_state = DECODE_ADDRESS;
        end else if (low_pkt_valid) begin
          w_next_state = LOAD_PARITY;
        end else begin
          w_next_state = LOAD_DATA;
        end
      end
      LOAD_PARITY: w_next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        w_next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      default: w_next_state = DECODE_ADDRESS;
    endcase

    // A read timeout on the selected port abandons the packet.
    if ((r_state != DECODE_ADDRESS) && w_soft_sel) begin
      w_next_state = DECODE_ADDRESS;
    end
  end

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b0;
    case (r_state)
      DECODE_ADDRESS: detect_add = 1'b1;
      LOAD_FIRST_DATA: begin
        lfd_state = 1'b1;
        busy      = 1'b1;
      end
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
      end
      LOAD_PARITY: begin
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      FIFO_FULL_STATE: begin
        full_state = 1'b1;
        busy       = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      WAIT_TILL_EMPTY: busy = 1'b1;
      CHECK_PARITY_ERROR: begin
        rst_int_reg = 1'b1;
        busy        = 1'b1;
      end
      default: detect_add = 1'b1;
    endcase
  end

  assign dest_addr = r_dest_addr;

endmodule
`default_nettype wire

// File: tb/tb_router_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_router_fsm                                                        |
// | Vector table plus hand-written sequences for router_fsm.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, write_enb_reg, busy;
  logic [1:0] dest_addr;

  router_fsm #(.DATA_WIDTH(8), .NUM_PORTS(3)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy), .dest_addr(dest_addr)
  );

  always #5 clock = ~clock;

  // Bench-local state names; only used to look up the required outputs.
  typedef enum logic [2:0] {S_DA, S_LFD, S_LD, S_LP, S_FFS, S_LAF, S_WTE, S_CPE} st_t;

  typedef struct {
    logic       rst;
    logic       pv;
    logic [7:0] din;
    logic       ff;
    logic [2:0] fe;
    logic [2:0] sr;
    logic       pd;
    logic       lpv;
    st_t        st;
    logic [1:0] da;
  } vec_t;

  typedef struct {
    st_t        st;
    logic [1:0] da;
    int         id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
  function automatic logic [7:0] outs_for(input st_t s);
    case (s)
      S_DA:    return 8'b1000_0000;
      S_LFD:   return 8'b0100_0001;
      S_LD:    return 8'b0010_0010;
      S_LP:    return 8'b0000_0011;
      S_FFS:   return 8'b0000_1001;
      S_LAF:   return 8'b0001_0011;
      S_WTE:   return 8'b0000_0001;
      default: return 8'b0000_0101;
    endcase
  endfunction

  function automatic void add(input logic rst, input logic pv, input logic [7:0] din,
                              input logic ff, input logic [2:0] fe, input logic [2:0] sr,
                              input logic pd, input logic lpv, input st_t st, input logic [1:0] da);
    vec_t v;
    v.rst = rst; v.pv = pv; v.din = din; v.ff = ff; v.fe = fe;
    v.sr = sr; v.pd = pd; v.lpv = lpv; v.st = st; v.da = da;
    vecs.push_back(v);
  endfunction

  task automatic drive(input vec_t v, input int id);
    exp_t e;
    reset = v.rst; pkt_valid = v.pv; data_in = v.din; fifo_full = v.ff;
    fifo_empty = v.fe; soft_reset = v.sr; parity_done = v.pd; low_pkt_valid = v.lpv;
    e.st = v.st; e.da = v.da; e.id = id;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    logic [9:0] act, req;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: no expectation queued");
    end else begin
      e   = sb.pop_front();
      act = {detect_add, lfd_state, ld_state, laf_state, full_state,
             rst_int_reg, write_enb_reg, busy, dest_addr};
      req = {outs_for(e.st), e.da};
      if (act !== req) begin
        n_bad++;
        $display("FAIL vec%0d (%s): got %b required %b", e.id, e.st.name(), act, req);
      end
    end
  endtask

  task automatic step(input vec_t v, input int id);
    drive(v, id);
    @(posedge clock);
    #1;
    check_out();
  endtask

  task automatic note_fail(input string what, input int act, input int req);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0d required %0d", what, act, req);
  endtask

  initial begin
    int id;
    int hold;
    int lat;
    vec_t v;

    //   rst pv  din    ff fe      sr      pd lpv  state  da
    add(1, 1, 8'h16, 0, 3'b111, 3'b000, 0, 0, S_DA,  2'd0); // reset wins over header
    add(0, 1, 8'h16, 0, 3'b111, 3'b000, 0, 0, S_LFD, 2'd2); // header port 2
    add(0, 1, 8'hA1, 0, 3'b111, 3'b000, 0, 0, S_LD,  2'd2);
    add(0, 1, 8'hA2, 0, 3'b111, 3'b000, 0, 0, S_LD,  2'd2);
    add(0, 1, 8'hA3, 0, 3'b111, 3'b000, 0, 0, S_LD,  2'd2);
    add(0, 1, 8'hA4, 0, 3'b111, 3'b000, 0, 0, S_LD,  2'd2);
    add(0, 1, 8'hA5, 0, 3'b111, 3'b000, 0, 0, S_LD,  2'd2);
    add(0, 0, 8'h5A, 0, 3'b111, 3'b000, 0, 0, S_LP,  2'd2); // parity byte
    add(0, 0, 8'h00, 0, 3'b111, 3'b000, 0, 0, S_CPE, 2'd2);
    add(0, 0, 8'h00, 0, 3'b111, 3'b000, 0, 0, S_DA,  2'd2);
    add(0, 1, 8'h15, 0, 3'b101, 3'b000, 0, 0, S_WTE, 2'd1); // port 1 busy
    add(0, 1, 8'h15, 0, 3'b101, 3'b000, 0, 0, S_WTE, 2'd1);
    add(0, 1, 8'h15, 0, 3'b101, 3'b000, 0, 0, S_WTE, 2'd1);
    add(0, 1, 8'h15, 0, 3'b101, 3'b000, 0, 0, S_WTE, 2'd1);
    add(0, 1, 8'h15, 0, 3'b111, 3'b000, 0, 0, S_LFD, 2'd1);
    add(0, 1, 8'hB1, 0, 3'b111, 3'b000, 0, 0, S_LD,  2'd1);
    add(0, 1, 8'hB2, 1, 3'b111, 3'b000, 0, 0, S_FFS, 2'd1); // FIFO full
    add(0, 1, 8'hB2, 1, 3'b111, 3'b000, 0, 0, S_FFS, 2'd1);
    add(0, 1, 8'hB2, 1, 3'b111, 3'b000, 0, 0, S_FFS, 2'd1);
    add(0, 1, 8'hB2, 0, 3'b111, 3'b000, 0, 0, S_LAF, 2'd1);
    add(0, 1, 8'hB3, 0, 3'b111, 3'b000, 0, 0, S_LD,  2'd1);
    add(0, 0, 8'hB3, 1, 3'b111, 3'b000, 0, 0, S_FFS, 2'd1); // full beats pkt end
    add(0, 0, 8'hB3, 0, 3'b111, 3'b000, 0, 0, S_LAF, 2'd1);
    add(0, 0, 8'hB3, 0, 3'b111, 3'b000, 0, 1, S_LP,  2'd1); // low_pkt_valid
    add(0, 0, 8'h00, 1, 3'b111, 3'b000, 0, 0, S_CPE, 2'd1);
    add(0, 0, 8'h00, 1, 3'b111, 3'b000, 0, 0, S_FFS, 2'd1); // full after parity
    add(0, 0, 8'h00, 0, 3'b111, 3'b000, 0, 0, S_LAF, 2'd1);
    add(0, 0, 8'h00, 0, 3'b111, 3'b000, 1, 1, S_DA,  2'd1); // parity_done wins
    add(0, 1, 8'h17, 0, 3'b111, 3'b000, 0, 0, S_DA,  2'd1); // address 3 dropped
    add(0, 0, 8'h16, 0, 3'b111, 3'b000, 0, 0, S_DA,  2'd1); // no pkt_valid
    add(0, 1, 8'h16, 0, 3'b011, 3'b000, 0, 0, S_WTE, 2'd2);
    add(0, 1, 8'h16, 0, 3'b011, 3'b001, 0, 0, S_WTE, 2'd2); // other port ignored
    add(0, 1, 8'h16, 0, 3'b011, 3'b100, 0, 0, S_DA,  2'd2); // selected port
    add(0, 1, 8'h15, 0, 3'b111, 3'b000, 0, 0, S_LFD, 2'd1);
    add(0, 1, 8'hC1, 0, 3'b111, 3'b000, 0, 0, S_LD,  2'd1);
    add(1, 1, 8'hC2, 0, 3'b111, 3'b010, 0, 0, S_DA,  2'd0); // reset + soft reset
    add(0, 1, 8'h14, 0, 3'b111, 3'b001, 0, 0, S_LFD, 2'd0); // soft reset idle in DA
    add(0, 1, 8'hD1, 0, 3'b111, 3'b001, 0, 0, S_DA,  2'd0); // soft reset in LFD
    add(0, 0, 8'h00, 0, 3'b111, 3'b000, 0, 0, S_DA,  2'd0);

    id = 0;
    foreach (vecs[i]) begin
      step(vecs[i], id);
      id++;
    end

    // Random-length wait on a busy port 0, then bounded wait for the header load.
    hold = $urandom_range(1, 6);
    add(0, 1, 8'h24, 0, 3'b110, 3'b000, 0, 0, S_WTE, 2'd0);
    v = vecs[vecs.size()-1];
    for (int k = 0; k <= hold; k++) begin
      step(v, id);
      id++;
    end
    fifo_empty = 3'b111;
    lat = 0;
    while (!lfd_state && lat < 4) begin
      @(posedge clock);
      #1;
      lat++;
    end
    n_cmp++;
    if (lat != 1) begin
      n_bad++;
      $display("FAIL wte_release_latency: got %0d required 1", lat);
    end

    // Parity latency: pkt_valid falls in LOAD_DATA, rst_int_reg two clocks later.
    add(0, 1, 8'hE1, 0, 3'b111, 3'b000, 0, 0, S_LD, 2'd0);
    step(vecs[vecs.size()-1], id);
    id++;
    pkt_valid = 1'b0;
    lat = 0;
    while (!rst_int_reg && lat < 6) begin
      @(posedge clock);
      #1;
      lat++;
    end
    if (lat != 2) begin
      note_fail("parity_to_rst_int_latency", lat, 2);
    end else begin
      n_cmp++;
    end
    @(posedge clock);
    #1;
    n_cmp++;
    if (!detect_add || busy || write_enb_reg) begin
      n_bad++;
      $display("FAIL back_to_decode: got da=%b busy=%b we=%b required 1 0 0",
               detect_add, busy, write_enb_reg);
    end

    if (sb.size() != 0) note_fail("scoreboard_leftover", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Control FSM of the 1x3 router; sequences the router_reg datapath and the write side of the three output FIFOs.
- Decodes the destination address from the header byte, waits for the destination FIFO to drain, and steps router_reg through header, payload, after-full and parity load.
- Drives the datapath strobes detect_add, lfd_state, ld_state, laf_state, full_state and rst_int_reg.
- Drives write_enb_reg and busy towards the source, synchronizer and FIFOs.

Parameters:
- DATA_WIDTH, 8, width of data_in; only bits [1:0] (destination address) are used.
- NUM_PORTS, 3, number of destination FIFOs; addresses NUM_PORTS..3 are invalid.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- pkt_valid  input  1  source asserts this for header and payload; it drops on the parity byte.
- data_in  input  DATA_WIDTH  packet byte; the header carries the address in [1:0].
- fifo_full  input  1  full flag of the currently selected destination FIFO (from the synchronizer).
- fifo_empty  input  NUM_PORTS  empty flags, one per destination FIFO.
- soft_reset  input  NUM_PORTS  per-FIFO read-timeout resets from the synchronizer.
- parity_done  input  1  from router_reg.
- low_pkt_valid  input  1  from router_reg.
- detect_add  output  1  high in DECODE_ADDRESS.
- lfd_state  output  1  high in LOAD_FIRST_DATA.
- ld_state  output  1  high in LOAD_DATA.
- laf_state  output  1  high in LOAD_AFTER_FULL.
- full_state  output  1  high in FIFO_FULL_STATE.
- rst_int_reg  output  1  high in CHECK_PARITY_ERROR.
- write_enb_reg  output  1  FIFO write enable.
- busy  output  1  source must hold data_in and not advance.
- dest_addr  output  2  latched destination address.

Behaviour:
- One state register; all outputs are Moore, decoded from the state register only.
  - dest_addr is the exception: it is a register.
- Reset (synchronous, any state):
  - state goes to DECODE_ADDRESS and dest_addr goes to 0.
  - Outputs after reset: detect_add=1; every other strobe, write_enb_reg and busy = 0.
- Address handling in DECODE_ADDRESS:
  - When pkt_valid=1 and data_in[1:0] < NUM_PORTS, dest_addr <= data_in[1:0] on that edge.
  - dest_addr holds its value in every other state.
- DECODE_ADDRESS transitions:
  - pkt_valid, valid address, fifo_empty[addr]=1 -> LOAD_FIRST_DATA.
  - pkt_valid, valid address, fifo_empty[addr]=0 -> WAIT_TILL_EMPTY.
  - Otherwise stay. Address 2'b11 is dropped: no latch, no write, no busy.
- WAIT_TILL_EMPTY: fifo_empty[dest_addr]=1 -> LOAD_FIRST_DATA, else stay.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally; this is a 1-cycle header load.
- LOAD_DATA transitions, in priority order:
  - fifo_full -> FIFO_FULL_STATE.
  - else pkt_valid=0 -> LOAD_PARITY.
  - else stay.
- FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL, else stay.
- LOAD_AFTER_FULL transitions, in priority order:
  - parity_done -> DECODE_ADDRESS.
  - else low_pkt_valid -> LOAD_PARITY.
  - else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
- Soft reset:
  - soft_reset[dest_addr]=1 in any state except DECODE_ADDRESS forces DECODE_ADDRESS next cycle.
  - It overrides all other transitions but not reset.
  - soft_reset of a non-selected port is ignored.
- Output decode:
  - write_enb_reg = LOAD_DATA | LOAD_AFTER_FULL | LOAD_PARITY.
  - busy = LOAD_FIRST_DATA | FIFO_FULL_STATE | LOAD_AFTER_FULL | LOAD_PARITY | CHECK_PARITY_ERROR | WAIT_TILL_EMPTY.
  - busy is low only in DECODE_ADDRESS and LOAD_DATA.
  - The strobes are exactly one-hot-decoded from state; never two strobes high together.
- Timing:
  - Latency from header (pkt_valid=1 with an empty FIFO) to lfd_state=1 is one clock.
  - Latency from parity byte (pkt_valid falls in LOAD_DATA) to rst_int_reg=1 is two clocks.
- Simultaneous events:
  - In LOAD_DATA, fifo_full together with pkt_valid=0 goes to FIFO_FULL_STATE (full wins).
  - reset together with soft_reset: reset wins, which gives the same result.
- Reset mid-packet: any state returns to DECODE_ADDRESS; no write_enb_reg pulse is produced.

Decomposition:
- Package router_pkg:
  - enumerated state_t with the 8 states above, binary encoding.
  - ADDR_INVALID = 2'b11.
  - NUM_PORTS.
- No sub-module. Next-state logic, the address register and output decode form a single module.

Test Plan:
- Reset: assert reset with pkt_valid=1 and data_in=8'h16 -> next edge detect_add=1, busy=0, write_enb_reg=0, dest_addr=0.
- Normal packet to port 2:
  - Stimulus: header 8'h16 with fifo_empty=3'b111, then 5 payload bytes, then pkt_valid=0.
  - Required sequence: DECODE -> LFD (busy=1) -> LD for 5 cycles (write_enb_reg=1, busy=0) -> LOAD_PARITY -> CHECK_PARITY_ERROR (rst_int_reg=1) -> DECODE.
- Busy destination:
  - Stimulus: header 8'h15 with fifo_empty[1]=0.
  - Required: WAIT_TILL_EMPTY with busy=1 for 4 cycles; after fifo_empty[1]=1, next cycle lfd_state=1 and dest_addr=2'd1.
- FIFO full mid-payload:
  - Stimulus: fifo_full=1 in LOAD_DATA, held 3 cycles.
  - Required: full_state=1 and write_enb_reg=0 for those cycles; then laf_state=1. With low_pkt_valid=0 and parity_done=0, next state is LD.
- Invalid address and soft reset:
  - Header 8'h17 -> stays in DECODE and dest_addr is unchanged.
  - soft_reset[dest_addr]=1 in WAIT_TILL_EMPTY -> DECODE next cycle.
  - soft_reset on another port -> no state change.
